// File: rtl/bk_adder_pipe.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// Define BK_ADDER_PIPE_OVF_EN to add the registered signed-overflow output ovf_o.
module bk_adder_pipe #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_i,
   input  logic             sub_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o
`ifdef BK_ADDER_PIPE_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   localparam int LOG = $clog2(WIDTH);

   logic v1, v2, v3;
   logic ld1, ld2, ld3;

   // Load enables ripple backwards so an empty stage fills even while later stages stall.
   assign ld3         = ~v3 | out_ready_i;
   assign ld2         = ~v2 | ld3;
   assign ld1         = ~v1 | ld2;
   assign in_ready_o  = ld1;
   assign out_valid_o = v3;

   // Stage 1: operand conditioning and bitwise generate/propagate.
   logic [WIDTH-1:0] b_cond;
   logic [WIDTH-1:0] g1, p1;
   logic             c1;
`ifdef BK_ADDER_PIPE_OVF_EN
   logic             a_msb1, b_msb1, a_msb2, b_msb2;
`endif

   assign b_cond = sub_i ? ~b_i : b_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         v1 <= 1'b0;
      end else if (ld1) begin
         v1 <= in_valid_i;
         if (in_valid_i) begin
            g1 <= a_i & b_cond;
            p1 <= a_i ^ b_cond;
            c1 <= carry_i ^ sub_i;
`ifdef BK_ADDER_PIPE_OVF_EN
            a_msb1 <= a_i[WIDTH-1];
            b_msb1 <= b_cond[WIDTH-1];
`endif
         end
      end
   end

   // Stage 2: prefix tree. Carry-in is merged into bit 0, so group generate of [i:0] is C[i+1].
   logic [WIDTH-1:0] gu [0:LOG];
   logic [WIDTH-1:0] pu [0:LOG];
   logic [WIDTH-1:0] gd [0:LOG-1];
   logic [WIDTH:0]   c2;
   logic [WIDTH-1:0] p2;

   assign gu[0] = {g1[WIDTH-1:1], g1[0] | (p1[0] & c1)};
   assign pu[0] = p1;

   for (genvar l = 0; l < LOG; l++) begin : g_up
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_dot
            assign gu[l+1][i] = gu[l][i] | (pu[l][i] & gu[l][i-(2**l)]);
            assign pu[l+1][i] = pu[l][i] & pu[l][i-(2**l)];
         end else begin : g_pass
            assign gu[l+1][i] = gu[l][i];
            assign pu[l+1][i] = pu[l][i];
         end
      end
   end

   assign gd[0] = gu[LOG];

   for (genvar d = 0; d < LOG - 1; d++) begin : g_down
      localparam int L = LOG - 2 - d;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if ((i >= 3 * (2 ** L) - 1) && (((i + 1 - (2 ** L)) % (2 ** (L + 1))) == 0)) begin : g_dot
            assign gd[d+1][i] = gd[d][i] | (pu[LOG][i] & gd[d][i-(2**L)]);
         end else begin : g_pass
            assign gd[d+1][i] = gd[d][i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         v2 <= 1'b0;
      end else if (ld2) begin
         v2 <= v1;
         if (v1) begin
            c2 <= {gd[LOG-1], c1};
            p2 <= p1;
`ifdef BK_ADDER_PIPE_OVF_EN
            a_msb2 <= a_msb1;
            b_msb2 <= b_msb1;
`endif
         end
      end
   end

   // Stage 3: registered sum; held while the consumer stalls.
   logic [WIDTH-1:0] sum_next;
   assign sum_next = p2 ^ c2[WIDTH-1:0];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         v3      <= 1'b0;
         sum_o   <= '0;
         carry_o <= 1'b0;
`ifdef BK_ADDER_PIPE_OVF_EN
         ovf_o   <= 1'b0;
`endif
      end else if (ld3) begin
         v3 <= v2;
         if (v2) begin
            sum_o   <= sum_next;
            carry_o <= c2[WIDTH];
`ifdef BK_ADDER_PIPE_OVF_EN
            ovf_o   <= (a_msb2 == b_msb2) & (sum_next[WIDTH-1] != a_msb2);
`endif
         end
      end
   end

endmodule
